// File: rtl/sequence_player.sv
// Plays the stored Simon colour sequence to the LED driver, oldest colour first,
// with fixed lit/dark timing, and pulses done once the final gap has elapsed.
module sequence_player #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int MAX_LEN    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [5:0]             round_len,
    input  logic [MAX_LEN:0][1:0]  segment,
    output logic                   busy,
    output logic                   led_on,
    output logic [1:0]             led_colour,
    output logic                   done
);

    localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ON_LAST   = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST  = TW'(OFF_CYCLES - 1);
    localparam logic [5:0]    MAX_LEN_V = 6'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      colour_q, colour_d;
    logic            busy_q, busy_d;
    logic            led_on_q, led_on_d;
    logic            done_q, done_d;
    logic [5:0]      len_s;

    // Next-state, index, timer and captured-colour logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        colour_d = colour_q;
        len_s    = (round_len > MAX_LEN_V) ? MAX_LEN_V : round_len;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_s == 6'd0) begin
                        state_d = FIN;
                    end else begin
                        state_d  = SHOW;
                        idx_d    = len_s;
                        timer_d  = '0;
                        colour_d = segment[len_s];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHOW: begin
                // Colour was latched on entry, so store writes here cannot disturb it.
                if (timer_q == ON_LAST) begin
                    state_d  = GAP;
                    timer_d  = '0;
                    colour_d = 2'b00;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GAP: begin
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    if (idx_q == 6'd1) begin
                        state_d = FIN;
                    end else begin
                        state_d  = SHOW;
                        idx_d    = idx_q - 6'd1;
                        colour_d = segment[idx_q - 6'd1];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d   = (state_d == SHOW) || (state_d == GAP);
        led_on_d = (state_d == SHOW);
        done_d   = (state_d == FIN);
    end

    // State and registered outputs; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= 6'd0;
            timer_q  <= '0;
            colour_q <= 2'b00;
            busy_q   <= 1'b0;
            led_on_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            colour_q <= colour_d;
            busy_q   <= busy_d;
            led_on_q <= led_on_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign led_on     = led_on_q;
    assign led_colour = colour_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with short lit/dark timing (3 on, 2 off).
module tb_sequence_player;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [5:0]       round_len;
    logic [32:0][1:0] segment;
    logic             busy;
    logic             led_on;
    logic [1:0]       led_colour;
    logic             done;

    int n_cmp = 0;
    int n_mis = 0;

    sequence_player #(
        .ON_CYCLES (3),
        .OFF_CYCLES(2),
        .MAX_LEN   (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .round_len (round_len),
        .segment   (segment),
        .busy      (busy),
        .led_on    (led_on),
        .led_colour(led_colour),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_led_on"}, 32'(led_on), 32'd0);
        chk({tag, "_colour"}, 32'(led_colour), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Plays round_len=3 with segment[1]=2,[2]=1,[3]=3 and checks every cycle.
    task automatic play3(input string tag, input int start_cyc_a, input int start_cyc_b,
                         input int seg_cyc);
        logic [1:0] exp_col [17];
        exp_col = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0,
                    2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
        round_len = 6'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            chk($sformatf("%s_c%0d_colour", tag, c), 32'(led_colour), 32'(exp_col[c-1]));
            chk($sformatf("%s_c%0d_led_on", tag, c), 32'(led_on),
                (exp_col[c-1] != 2'd0) ? 32'd1 : 32'd0);
            chk($sformatf("%s_c%0d_busy", tag, c), 32'(busy), (c <= 15) ? 32'd1 : 32'd0);
            chk($sformatf("%s_c%0d_done", tag, c), 32'(done), (c == 16) ? 32'd1 : 32'd0);
            start = (c == start_cyc_a) || (c == start_cyc_b);
            if (c == seg_cyc) begin
                segment[3] = 2'd0;
            end
            tick();
        end
        start = 1'b0;
        segment[3] = 2'd3;
    endtask

    initial begin
        int shows;
        int done_at;
        logic prev_on;

        reset = 1'b0;
        start = 1'b0;
        round_len = 6'd0;
        segment = '0;
        segment[1] = 2'd2;
        segment[2] = 2'd1;
        segment[3] = 2'd3;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // Basic three-colour round.
        play3("t1", 0, 0, 0);

        // Zero-length round: immediate done, nothing lit.
        round_len = 6'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_led_on", 32'(led_on), 32'd0);
        tick();
        chk_all_zero("t2_after");

        // Over-long round is clamped to 32 colours.
        for (int i = 1; i <= 31; i++) begin
            segment[i] = 2'd2;
        end
        segment[32] = 2'd1;
        round_len = 6'd40;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_first_colour", 32'(led_colour), 32'd1);
        shows = 1;
        prev_on = led_on;
        done_at = 0;
        for (int c = 2; c <= 220 && done_at == 0; c++) begin
            tick();
            if (led_on && !prev_on) begin
                shows++;
            end
            prev_on = led_on;
            if (done) begin
                done_at = c;
            end
        end
        chk("t3_shows", 32'(shows), 32'd32);
        chk("t3_done_cycle", 32'(done_at), 32'd161);
        tick();
        segment = '0;
        segment[1] = 2'd2;
        segment[2] = 2'd1;
        segment[3] = 2'd3;

        // Reset during the second colour aborts with no done.
        round_len = 6'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) begin
            tick();
        end
        chk("t4_second_colour", 32'(led_colour), 32'd1);
        chk("t4_second_on", 32'(led_on), 32'd1);
        reset = 1'b0;
        tick();
        chk_all_zero("t4_in_reset");
        reset = 1'b1;
        tick();
        chk_all_zero("t4_released");
        tick();
        chk_all_zero("t4_idle");
        play3("t4_replay", 0, 0, 0);

        // Start during SHOW and during FIN is ignored.
        play3("t5", 2, 16, 0);

        // Store write during SHOW does not alter the lit colour.
        play3("t6", 0, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
